// File: rtl/pos_pid_mc.sv
// Multi-channel position PID: one time-multiplexed datapath and a single shared multiplier serve
// NCH axes, each with its own target, sample, integrator, bypass and overrun state.
module pos_pid_mc #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned DW    = 16,
    parameter int unsigned GW    = 16,
    parameter int unsigned ISW   = 24,
    parameter int unsigned SHIFT = 10
) (
    input  logic              clk_pid,
    input  logic              sys_rstn,
    input  logic [GW-1:0]     kp,
    input  logic [GW-1:0]     ki,
    input  logic [GW-1:0]     kd,
    input  logic [DW-1:0]     dac_limit,
    input  logic [ISW-1:0]    pid_i_saturation,
    input  logic [NCH-1:0]    pid_en,
    input  logic [NCH-1:0]    spi_new_target_valid,
    input  logic [NCH*DW-1:0] pos_target,
    input  logic [NCH-1:0]    pos_adc_data_valid,
    input  logic [NCH*DW-1:0] pos_adc,
    output logic [NCH*DW-1:0] pos_dac,
    output logic [NCH-1:0]    pos_dac_valid,
    output logic [NCH-1:0]    overrun
);
    localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned EW  = DW + 1;
    localparam int unsigned DEW = DW + 2;
    localparam int unsigned PW  = GW + 1 + DEW;
    localparam int unsigned IW  = ISW + 1;
    localparam int unsigned AW  = ((PW > IW) ? PW : IW) + 2;

    typedef enum logic [2:0] {StIdle, StLoad, StMulP, StMulI, StMulD, StSum, StWrite} state_e;

    state_e               state_q;
    logic [CW-1:0]        ch_q;
    logic [CW-1:0]        rr_q;
    logic [NCH-1:0]       adc_vld_q;
    logic [NCH-1:0]       tgt_vld_q;
    logic [NCH-1:0]       pending_q;
    logic [NCH-1:0]       kick_q;
    logic signed [DW-1:0] target_q [NCH];
    logic signed [DW-1:0] adc_q    [NCH];
    logic signed [DW-1:0] dac_q    [NCH];
    logic signed [IW-1:0] integ_q  [NCH];
    logic signed [EW-1:0] e_prev_q [NCH];
    logic signed [EW-1:0] e_q;
    logic signed [DEW-1:0] de_q;
    logic signed [DW-1:0] tgt_w_q;
    logic signed [DW-1:0] u_q;
    logic                 bypass_q;
    logic signed [PW-1:0] p_q;
    logic signed [PW-1:0] d_q;

    logic [NCH-1:0] adc_rise;
    logic [NCH-1:0] tgt_rise;
    logic [NCH-1:0] req;
    logic [NCH-1:0] load_clr;
    assign adc_rise = pos_adc_data_valid & ~adc_vld_q;
    assign tgt_rise = spi_new_target_valid & ~tgt_vld_q;
    // A fresh edge is eligible in the same cycle it is seen, giving the 6-cycle latency.
    assign req      = pending_q | adc_rise;
    assign load_clr = (state_q == StLoad) ? (NCH'(1) << ch_q) : '0;

    logic [NCH-1:0] req_rot;
    logic           pick_found;
    logic [CW:0]    pick_sum;
    logic [CW-1:0]  pick_ch;
    always_comb begin
        req_rot    = NCH'({req, req} >> rr_q);
        pick_found = 1'b0;
        pick_sum   = {1'b0, rr_q};
        for (int k = 0; k < NCH; k++) begin
            if (!pick_found && req_rot[k]) begin
                pick_found = 1'b1;
                pick_sum   = {1'b0, rr_q} + (CW+1)'(k);
            end
        end
        pick_ch = (pick_sum >= (CW+1)'(NCH)) ? CW'(pick_sum - (CW+1)'(NCH)) : CW'(pick_sum);
    end

    logic signed [EW-1:0]  e_load;
    logic signed [DEW-1:0] de_load;
    assign e_load  = {target_q[ch_q][DW-1], target_q[ch_q]} - {adc_q[ch_q][DW-1], adc_q[ch_q]};
    assign de_load = {e_load[EW-1], e_load} - {e_prev_q[ch_q][EW-1], e_prev_q[ch_q]};

    logic [GW-1:0]         mul_gain;
    logic signed [DEW-1:0] mul_x;
    logic signed [PW-1:0]  mul_p;
    always_comb begin
        mul_gain = kp;
        mul_x    = {e_q[EW-1], e_q};
        if (state_q == StMulI) begin
            mul_gain = ki;
        end else if (state_q == StMulD) begin
            mul_gain = kd;
            mul_x    = de_q;
        end
    end
    assign mul_p = PW'($signed({1'b0, mul_gain})) * PW'(mul_x);

    logic signed [AW-1:0] i_lim;
    logic signed [AW-1:0] i_sum;
    logic signed [AW-1:0] i_clamped;
    assign i_lim = $signed(AW'(pid_i_saturation));
    assign i_sum = AW'(integ_q[ch_q]) + AW'(mul_p >>> SHIFT);
    always_comb begin
        i_clamped = i_sum;
        if (i_sum > i_lim) begin
            i_clamped = i_lim;
        end else if (i_sum < -i_lim) begin
            i_clamped = -i_lim;
        end
    end

    logic signed [PW:0]   pd_sum;
    logic signed [AW-1:0] u_lim;
    logic signed [AW-1:0] u_src;
    logic signed [AW-1:0] u_clamped;
    assign pd_sum = {p_q[PW-1], p_q} + {d_q[PW-1], d_q};
    assign u_lim  = $signed(AW'(dac_limit));
    always_comb begin
        u_src     = bypass_q ? AW'(tgt_w_q) : AW'(pd_sum >>> SHIFT) + AW'(integ_q[ch_q]);
        u_clamped = u_src;
        if (u_src > u_lim) begin
            u_clamped = u_lim;
        end else if (u_src < -u_lim) begin
            u_clamped = -u_lim;
        end
    end

    always_comb begin
        pos_dac = '0;
        for (int i = 0; i < NCH; i++) begin
            pos_dac[i*DW +: DW] = dac_q[i];
        end
    end

    always_ff @(posedge clk_pid or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q       <= StIdle;
            ch_q          <= '0;
            rr_q          <= '0;
            adc_vld_q     <= '0;
            tgt_vld_q     <= '0;
            pending_q     <= '0;
            kick_q        <= '0;
            overrun       <= '0;
            pos_dac_valid <= '0;
            e_q           <= '0;
            de_q          <= '0;
            tgt_w_q       <= '0;
            u_q           <= '0;
            bypass_q      <= 1'b0;
            p_q           <= '0;
            d_q           <= '0;
            for (int i = 0; i < NCH; i++) begin
                target_q[i] <= '0;
                adc_q[i]    <= '0;
                dac_q[i]    <= '0;
                integ_q[i]  <= '0;
                e_prev_q[i] <= '0;
            end
        end else begin
            adc_vld_q     <= pos_adc_data_valid;
            tgt_vld_q     <= spi_new_target_valid;
            pos_dac_valid <= '0;
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        ch_q    <= pick_ch;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    e_q      <= e_load;
                    de_q     <= kick_q[ch_q] ? '0 : de_load;
                    tgt_w_q  <= target_q[ch_q];
                    bypass_q <= ~pid_en[ch_q];
                    if (!pid_en[ch_q]) begin
                        integ_q[ch_q]  <= '0;
                        e_prev_q[ch_q] <= '0;
                    end
                    state_q <= StMulP;
                end
                StMulP: begin
                    p_q     <= mul_p;
                    state_q <= StMulI;
                end
                StMulI: begin
                    if (!bypass_q) begin
                        integ_q[ch_q] <= IW'(i_clamped);
                    end
                    state_q <= StMulD;
                end
                StMulD: begin
                    d_q     <= mul_p;
                    state_q <= StSum;
                end
                StSum: begin
                    u_q     <= DW'(u_clamped);
                    state_q <= StWrite;
                end
                StWrite: begin
                    dac_q[ch_q]         <= u_q;
                    pos_dac_valid[ch_q] <= 1'b1;
                    e_prev_q[ch_q]      <= bypass_q ? '0 : e_q;
                    rr_q                <= (ch_q == CW'(NCH - 1)) ? '0 : ch_q + CW'(1);
                    state_q             <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
            // New edges win over the LOAD clear so an edge during service is queued again.
            pending_q <= (pending_q & ~load_clr) | adc_rise;
            kick_q    <= (kick_q & ~load_clr) | tgt_rise;
            overrun   <= overrun | (adc_rise & pending_q & ~load_clr);
            for (int i = 0; i < NCH; i++) begin
                if (adc_rise[i]) begin
                    adc_q[i] <= pos_adc[i*DW +: DW];
                end
                if (tgt_rise[i]) begin
                    target_q[i] <= pos_target[i*DW +: DW];
                end
            end
        end
    end
endmodule

// File: tb/tb_pos_pid_mc.sv
// Bench for pos_pid_mc: a table of single-sample vectors plus hand-written multi-cycle sequences,
// all expectations queued in a scoreboard and checked whenever pos_dac_valid pulses.
module tb_pos_pid_mc;
    localparam int NCH = 2;
    localparam int DW  = 16;
    localparam int GW  = 16;
    localparam int ISW = 24;

    logic              clk = 1'b0;
    logic              sys_rstn;
    logic [GW-1:0]     kp;
    logic [GW-1:0]     ki;
    logic [GW-1:0]     kd;
    logic [DW-1:0]     dac_limit;
    logic [ISW-1:0]    pid_i_saturation;
    logic [NCH-1:0]    pid_en;
    logic [NCH-1:0]    spi_new_target_valid;
    logic [NCH*DW-1:0] pos_target;
    logic [NCH-1:0]    pos_adc_data_valid;
    logic [NCH*DW-1:0] pos_adc;
    logic [NCH*DW-1:0] pos_dac;
    logic [NCH-1:0]    pos_dac_valid;
    logic [NCH-1:0]    overrun;

    pos_pid_mc #(.NCH(NCH), .DW(DW), .GW(GW), .ISW(ISW), .SHIFT(10)) dut (
        .clk_pid              (clk),
        .sys_rstn             (sys_rstn),
        .kp                   (kp),
        .ki                   (ki),
        .kd                   (kd),
        .dac_limit            (dac_limit),
        .pid_i_saturation     (pid_i_saturation),
        .pid_en               (pid_en),
        .spi_new_target_valid (spi_new_target_valid),
        .pos_target           (pos_target),
        .pos_adc_data_valid   (pos_adc_data_valid),
        .pos_adc              (pos_adc),
        .pos_dac              (pos_dac),
        .pos_dac_valid        (pos_dac_valid),
        .overrun              (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int ch;
        bit new_tgt;
        int tgt;
        int adc;
        int kp;
        int ki;
        int kd;
        bit en;
        int exp_dac;
    } vec_t;

    typedef struct {
        int ch;
        int val;
        int due;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int dac_of(input int c);
        return int'($signed(pos_dac[c*DW +: DW]));
    endfunction

    always @(negedge clk) begin
        if (sys_rstn) begin
            for (int c = 0; c < NCH; c++) begin
                if (pos_dac_valid[c]) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_valid_channel", c, -1);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("valid_channel", c, e.ch);
                        check("dac_value", dac_of(c), e.val);
                        check("valid_cycle", cyc, e.due);
                    end
                end
            end
        end
    end

    task automatic push(input int ch, input int val, input int due);
        exp_t e;
        e.ch  = ch;
        e.val = val;
        e.due = due;
        sb_q.push_back(e);
    endtask

    // Entered at a negedge; returns at the following negedge with n = edge-sampling cycle.
    task automatic pulse(input logic [NCH-1:0] adc_m, input logic [NCH-1:0] tgt_m, output int n);
        pos_adc_data_valid   = adc_m;
        spi_new_target_valid = tgt_m;
        @(posedge clk);
        #1 n = cyc;
        @(negedge clk);
        pos_adc_data_valid   = '0;
        spi_new_target_valid = '0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 60) begin
            @(posedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d outputs outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic set_adc(input int ch, input int adc);
        pos_adc[ch*DW +: DW] = DW'(adc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[18];
        int n;
        logic [NCH-1:0] am;
        logic [NCH-1:0] tm;

        //          ch new  tgt    adc  kp    ki    kd    en exp
        vecs[0]  = '{0, 1,  1000,  0,    1024, 0,    0,    1,  1000};
        vecs[1]  = '{0, 0,  1000,  0,    8192, 0,    0,    1,  5000};
        vecs[2]  = '{0, 1, -1000,  0,    8192, 0,    0,    1, -5000};
        vecs[3]  = '{0, 1,  1000,  0,    0,    1024, 0,    1,  1000};
        vecs[4]  = '{0, 0,  1000,  0,    0,    1024, 0,    1,  2000};
        vecs[5]  = '{0, 0,  1000,  0,    0,    1024, 0,    1,  3000};
        vecs[6]  = '{0, 0,  1000,  0,    0,    1024, 0,    1,  3000};
        vecs[7]  = '{0, 0,  1000,  0,    0,    1024, 0,    1,  3000};
        vecs[8]  = '{0, 1, -1000,  0,    0,    1024, 0,    1,  2000};
        vecs[9]  = '{0, 0, -1000,  500,  1024, 0,    0,    1,  500};
        vecs[10] = '{1, 1,  500,   0,    0,    0,    1024, 1,  0};
        vecs[11] = '{1, 0,  500,   100,  0,    0,    1024, 1, -100};
        vecs[12] = '{1, 0,  500,   100,  0,    1024, 0,    1,  400};
        vecs[13] = '{1, 1,  7000,  100,  0,    1024, 0,    0,  5000};
        vecs[14] = '{1, 0,  7000,  0,    0,    0,    0,    1,  0};
        vecs[15] = '{1, 1, -7000,  0,    0,    0,    0,    0, -5000};
        vecs[16] = '{1, 1,  7000,  6500, 1024, 0,    0,    1,  500};
        vecs[17] = '{1, 0,  7000,  7003, 512,  0,    0,    1, -2};

        sys_rstn             = 1'b0;
        kp                   = '0;
        ki                   = '0;
        kd                   = '0;
        dac_limit            = DW'(5000);
        pid_i_saturation     = ISW'(3000);
        pid_en               = '1;
        spi_new_target_valid = '0;
        pos_target           = '0;
        pos_adc_data_valid   = '0;
        pos_adc              = '0;
        repeat (3) @(negedge clk);
        check("reset_pos_dac", int'(pos_dac), 0);
        check("reset_pos_dac_valid", int'(pos_dac_valid), 0);
        check("reset_overrun", int'(overrun), 0);
        sys_rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            kp = GW'(vecs[i].kp);
            ki = GW'(vecs[i].ki);
            kd = GW'(vecs[i].kd);
            pid_en[vecs[i].ch] = vecs[i].en;
            pos_target[vecs[i].ch*DW +: DW] = DW'(vecs[i].tgt);
            set_adc(vecs[i].ch, vecs[i].adc);
            am = '0;
            tm = '0;
            am[vecs[i].ch] = 1'b1;
            tm[vecs[i].ch] = vecs[i].new_tgt;
            pulse(am, tm, n);
            push(vecs[i].ch, vecs[i].exp_dac, n + 6);
            drain();
            if (i == 0) check("ch1_untouched", dac_of(1), 0);
        end

        // Simultaneous edges, rr at ch0: ch0 then ch1 back-to-back.
        kp = GW'(1024);
        ki = '0;
        kd = '0;
        set_adc(0, 0);
        set_adc(1, 6500);
        pulse(2'b11, 2'b00, n);
        push(0, 1000, n + 6);
        push(1, 500, n + 13);
        drain();

        // Single ch0 service moves rr to ch1, so the next tie serves ch1 first.
        set_adc(0, -500);
        pulse(2'b01, 2'b00, n);
        push(0, 1500, n + 6);
        drain();
        set_adc(0, 0);
        set_adc(1, 6000);
        pulse(2'b11, 2'b00, n);
        push(1, 1000, n + 6);
        push(0, 1000, n + 13);
        drain();
        check("no_overrun_yet", int'(overrun), 0);

        // Two ch0 samples while ch1 is in service: overrun, newest sample used.
        set_adc(1, 6500);
        pulse(2'b10, 2'b00, n);
        push(1, 500, n + 6);
        @(negedge clk);
        set_adc(0, 0);
        pulse(2'b01, 2'b00, am);
        @(negedge clk);
        set_adc(0, -500);
        pulse(2'b01, 2'b00, am);
        push(0, 1500, n + 13);
        drain();
        check("overrun_flags", int'(overrun), 1);

        // Reset while ch0 is in MUL_I: outputs clear at once, clean restart.
        set_adc(0, 0);
        pulse(2'b01, 2'b00, n);
        @(negedge clk);
        @(negedge clk);
        sys_rstn = 1'b0;
        #1;
        check("midrst_pos_dac", int'(pos_dac), 0);
        check("midrst_pos_dac_valid", int'(pos_dac_valid), 0);
        check("midrst_overrun", int'(overrun), 0);
        @(negedge clk);
        @(negedge clk);
        sys_rstn = 1'b1;
        @(negedge clk);
        pos_target[0 +: DW] = DW'(1000);
        set_adc(0, 0);
        pulse(2'b01, 2'b01, n);
        push(0, 1000, n + 6);
        drain();
        set_adc(1, -200);
        pulse(2'b10, 2'b00, n);
        push(1, 200, n + 6);
        drain();
        check("post_rst_overrun", int'(overrun), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
